// File: rtl/mult_pkg.sv
// Shared types and constants for the serial radix-2^BPC multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_BPC   = 2;

    // Digit counter width; at least one bit so a single-digit build still has a counter.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
        int unsigned n;
        n = width / bpc;
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mult_serial_pp.sv
// Combinational partial product of the multiplicand magnitude and one BPC-bit digit.
module mult_serial_pp #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BPC   = 2
) (
    input  logic [WIDTH-1:0]     mag,
    input  logic [BPC-1:0]       digit,
    output logic [WIDTH+BPC-1:0] pp
);

    localparam int unsigned PPW = WIDTH + BPC;

    assign pp = PPW'(mag) * PPW'(digit);

endmodule

// File: rtl/mult_serial_param.sv
// Sequential sign-magnitude multiplier retiring BPC multiplier bits per cycle.
module mult_serial_param
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned BPC   = DEF_BPC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned N   = WIDTH / BPC;
    localparam int unsigned CW  = cnt_width(WIDTH, BPC);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned PPW = WIDTH + BPC;

    mult_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PPW-1:0]   pp;
    logic [PW-1:0]    acc_sum;
    logic             last;

    // Two's-complement negation maps the most negative value onto its own unsigned magnitude.
    assign a_mag   = (signed_mode && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign b_mag   = (signed_mode && b[WIDTH-1]) ? WIDTH'(-b) : b;
    assign last    = (cnt_q == CW'(N - 1));
    assign acc_sum = acc_q + (PW'(pp) << (BPC * cnt_q));

    mult_serial_pp #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_pp (
        .mag   (a_q),
        .digit (b_q[BPC-1:0]),
        .pp    (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            ST_RUN:           state_d = last ? ST_DONE : ST_RUN;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Datapath next values and state-decoded status outputs.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        neg_d = neg_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    a_d   = a_mag;
                    b_d   = b_mag;
                    neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                acc_d = acc_sum;
                b_d   = b_q >> BPC;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    cnt_d = '0;
                    p_d   = neg_q ? PW'(-acc_sum) : acc_sum;
                end
            end
            default: ;
        endcase
    end

    assign p = p_q;

endmodule

// File: tb/tb_mult_serial_param.sv
// Directed self-checking bench for mult_serial_param at WIDTH=16, BPC=2.
module tb_mult_serial_param;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int total = 0;
    int bad   = 0;

    mult_serial_param #(.WIDTH(16), .BPC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .p           (p)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic sm);
        longint sx, sy;
        if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({48'd0, x});
            sy = longint'({48'd0, y});
        end
        return 32'(sx * sy);
    endfunction

    // Ticks until done is seen; n counts ticks taken, bounded.
    task automatic wait_done(output int n, output int busy_cnt);
        n = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 50) begin
            tick();
            n++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic sm,
                          input logic [31:0] exp, input string tag);
        int n, bc;
        a = ta; b = tb_; signed_mode = sm; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); signed_mode = ~sm;
        wait_done(n, bc);
        check({tag, "_lat"}, 64'(n + 1), 64'd9);
        check({tag, "_busy"}, 64'(bc), 64'd8);
        check({tag, "_p"}, 64'(p), 64'(exp));
        tick();
        check({tag, "_1pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(p), 64'(exp));
    endtask

    initial begin
        int n, bc, dn;
        logic [15:0] ra, rb;
        logic        rs;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_p", 64'(p), 64'd0);

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "umax");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1m1");
        run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_minmin");
        run_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "s_min1");
        run_op(16'd0, 16'h1234, 1'b0, 32'h0, "zero");
        run_op(16'hFFFD, 16'd7, 1'b1, 32'hFFFFFFEB, "s_neg3x7");

        // Start re-asserted during RUN must not disturb the latched operands.
        a = 16'd3; b = 16'd7; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 16'd5; b = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dn++;
                check("ign_p", 64'(p), 64'd21);
            end
            tick();
        end
        check("ign_pulses", 64'(dn), 64'd1);
        check("ign_idle", 64'(busy), 64'd0);

        // Back-to-back: next start presented in every DONE cycle.
        a = 16'd0; b = 16'd7; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wait_done(n, bc);
            check("b2b_period", 64'(n + 1), 64'd9);
            check("b2b_p", 64'(p), 64'(ref_mul(16'(3 * i), 16'(i + 7), 1'b0)));
            if (i < 99) begin
                a = 16'(3 * (i + 1)); b = 16'(i + 8); start = 1'b1;
            end
            tick();
            start = 1'b0;
        end

        // Reset in the middle of RUN aborts cleanly.
        a = 16'd100; b = 16'd200; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_p", 64'(p), 64'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dn++;
            tick();
        end
        check("mid_rst_nodone", 64'(dn), 64'd0);
        run_op(16'd1234, 16'd567, 1'b0, 32'd699678, "post_rst");

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            run_op(ra, rb, rs, ref_mul(ra, rb, rs), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
